// File: rtl/core_bus_pkg.sv
// Shared constants and FSM state type for the core bus arbiter.
// Response, request and size codes match the downstream bus bridge.
package core_bus_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b10;

  localparam logic [1:0] REQ_READ  = 2'b00;
  localparam logic [1:0] REQ_WRITE = 2'b01;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_D = 2'b11;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

endpackage

// File: rtl/core_bus_arbiter_rr_pick.sv
// Combinational winner selection: fixed priority or round-robin from ptr.
// Produces a one-hot grant and its encoded index.
module rr_pick #(
  parameter int NUM_CH = 2,
  parameter int IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              mode,
  output logic [NUM_CH-1:0] gnt,
  output logic [IDX_W-1:0]  idx
);

  localparam logic [IDX_W:0] NCH = (IDX_W+1)'(NUM_CH);

  logic           found;
  logic [IDX_W:0] cand;

  // Walk channels in priority order; first requester wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (mode) begin
        cand = {1'b0, ptr} + i[IDX_W:0];
        if (cand >= NCH) cand = cand - NCH;
      end else begin
        cand = i[IDX_W:0];
      end
      if (!found && req[cand[IDX_W-1:0]]) begin
        found                 = 1'b1;
        gnt[cand[IDX_W-1:0]]  = 1'b1;
        idx                   = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/core_bus_arbiter.sv
// N-channel valid/ready arbiter onto a single downstream bus port.
// Optional BUSY timeout abort is enabled by defining ARB_TIMEOUT_EN.
module core_bus_arbiter
  import core_bus_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          m_valid,
  input  logic [2*NUM_CH-1:0]        m_req,
  input  logic [NUM_CH*ADDR_W-1:0]   m_addr,
  input  logic [NUM_CH*DATA_W-1:0]   m_wdata,
  input  logic [2*NUM_CH-1:0]        m_size,
  output logic [NUM_CH-1:0]          m_ready,
  output logic [2*NUM_CH-1:0]        m_resp,
  output logic [NUM_CH*DATA_W-1:0]   m_rdata,
  output logic                       s_valid,
  output logic [1:0]                 s_req,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_wdata,
  output logic [1:0]                 s_size,
  input  logic                       s_ready,
  input  logic [1:0]                 s_resp,
  input  logic [DATA_W-1:0]          s_rdata,
  output logic [$clog2(NUM_CH)-1:0]  grant_id,
  output logic                       busy
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);

  state_t            state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [NUM_CH-1:0] pick_gnt;
  logic [IDX_W-1:0]  pick_idx;
  logic [1:0]        sel_req;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [1:0]        sel_size;
  logic              done;
  logic              tmo;

  rr_pick #(
    .NUM_CH (NUM_CH),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req  (m_valid),
    .ptr  (rr_ptr),
    .mode (ARB_MODE != 0),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  // One-hot AND-OR mux of the winning channel's request fields.
  always_comb begin
    sel_req   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_size  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick_gnt[i]) begin
        sel_req   = sel_req   | m_req[2*i +: 2];
        sel_addr  = sel_addr  | m_addr[ADDR_W*i +: ADDR_W];
        sel_wdata = sel_wdata | m_wdata[DATA_W*i +: DATA_W];
        sel_size  = sel_size  | m_size[2*i +: 2];
      end
    end
  end

  // Completion is dropped when reset lands in the same cycle.
  assign done = busy & s_ready & ~rst;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  assign tmo = busy & ~s_ready & ~rst &
               (tcnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  // Route completion back to the granted channel only.
  always_comb begin
    m_ready = '0;
    m_resp  = '0;
    m_rdata = '0;
    if (done | tmo) begin
      m_ready[grant_id]               = 1'b1;
      m_resp[2*grant_id +: 2]         = tmo ? RESP_ERR : s_resp;
      m_rdata[DATA_W*grant_id +: DATA_W] = tmo ? '0 : s_rdata;
    end
  end

  // Arbitration FSM with registered downstream request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      s_valid  <= 1'b0;
      s_req    <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_size   <= '0;
      grant_id <= '0;
      busy     <= 1'b0;
      rr_ptr   <= '0;
`ifdef ARB_TIMEOUT_EN
      tcnt     <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (|m_valid) begin
            state    <= BUSY;
            s_valid  <= 1'b1;
            busy     <= 1'b1;
            s_req    <= sel_req;
            s_addr   <= sel_addr;
            s_wdata  <= sel_wdata;
            s_size   <= sel_size;
            grant_id <= pick_idx;
`ifdef ARB_TIMEOUT_EN
            tcnt     <= '0;
`endif
          end
        end
        BUSY: begin
          if (done | tmo) begin
            state   <= IDLE;
            s_valid <= 1'b0;
            busy    <= 1'b0;
            rr_ptr  <= (grant_id == LAST) ? '0 : grant_id + 1'b1;
          end
`ifdef ARB_TIMEOUT_EN
          else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed scoreboard bench for core_bus_arbiter.
// Fixed-priority 2-channel DUT plus a 4-channel round-robin DUT.
module tb_core_bus_arbiter;
  import core_bus_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]   f_m_valid;
  logic [3:0]   f_m_req;
  logic [127:0] f_m_addr;
  logic [127:0] f_m_wdata;
  logic [3:0]   f_m_size;
  logic [1:0]   f_m_ready;
  logic [3:0]   f_m_resp;
  logic [127:0] f_m_rdata;
  logic         f_s_valid;
  logic [1:0]   f_s_req;
  logic [63:0]  f_s_addr;
  logic [63:0]  f_s_wdata;
  logic [1:0]   f_s_size;
  logic         f_s_ready;
  logic [1:0]   f_s_resp;
  logic [63:0]  f_s_rdata;
  logic [0:0]   f_grant_id;
  logic         f_busy;

  logic [3:0]   r_m_valid;
  logic [7:0]   r_m_req;
  logic [255:0] r_m_addr;
  logic [255:0] r_m_wdata;
  logic [7:0]   r_m_size;
  logic [3:0]   r_m_ready;
  logic [7:0]   r_m_resp;
  logic [255:0] r_m_rdata;
  logic         r_s_valid;
  logic [1:0]   r_s_req;
  logic [63:0]  r_s_addr;
  logic [63:0]  r_s_wdata;
  logic [1:0]   r_s_size;
  logic         r_s_ready;
  logic [1:0]   r_s_resp;
  logic [63:0]  r_s_rdata;
  logic [1:0]   r_grant_id;
  logic         r_busy;

  core_bus_arbiter #(
    .NUM_CH(2), .ADDR_W(64), .DATA_W(64),
    .ARB_MODE(0), .TIMEOUT_CYCLES(16)
  ) u_fix (
    .clk(clk), .rst(rst),
    .m_valid(f_m_valid), .m_req(f_m_req), .m_addr(f_m_addr),
    .m_wdata(f_m_wdata), .m_size(f_m_size),
    .m_ready(f_m_ready), .m_resp(f_m_resp), .m_rdata(f_m_rdata),
    .s_valid(f_s_valid), .s_req(f_s_req), .s_addr(f_s_addr),
    .s_wdata(f_s_wdata), .s_size(f_s_size),
    .s_ready(f_s_ready), .s_resp(f_s_resp), .s_rdata(f_s_rdata),
    .grant_id(f_grant_id), .busy(f_busy)
  );

  core_bus_arbiter #(
    .NUM_CH(4), .ADDR_W(64), .DATA_W(64),
    .ARB_MODE(1), .TIMEOUT_CYCLES(16)
  ) u_rr (
    .clk(clk), .rst(rst),
    .m_valid(r_m_valid), .m_req(r_m_req), .m_addr(r_m_addr),
    .m_wdata(r_m_wdata), .m_size(r_m_size),
    .m_ready(r_m_ready), .m_resp(r_m_resp), .m_rdata(r_m_rdata),
    .s_valid(r_s_valid), .s_req(r_s_req), .s_addr(r_s_addr),
    .s_wdata(r_s_wdata), .s_size(r_s_size),
    .s_ready(r_s_ready), .s_resp(r_s_resp), .s_rdata(r_s_rdata),
    .grant_id(r_grant_id), .busy(r_busy)
  );

  typedef struct {
    int          ch;
    logic [1:0]  req;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
  } exp_t;

  exp_t sbq[$];
  int   rq[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic f_set(input int ch, input logic [1:0] req,
                       input logic [63:0] addr, input logic [63:0] wd,
                       input logic [1:0] sz);
    exp_t e;
    f_m_req[2*ch +: 2]    = req;
    f_m_addr[64*ch +: 64] = addr;
    f_m_wdata[64*ch +: 64] = wd;
    f_m_size[2*ch +: 2]   = sz;
    e.ch = ch; e.req = req; e.addr = addr; e.wdata = wd; e.size = sz;
    sbq.push_back(e);
  endtask

  task automatic f_wait_grant();
    exp_t e;
    int n = 0;
    while (!f_s_valid && n < 20) begin
      step();
      n++;
    end
    chk("grant_valid", {63'd0, f_s_valid}, 64'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("grant_id", {63'd0, f_grant_id}, 64'(e.ch));
      chk("s_addr", f_s_addr, e.addr);
      chk("s_req", {62'd0, f_s_req}, {62'd0, e.req});
      chk("s_wdata", f_s_wdata, e.wdata);
      chk("s_size", {62'd0, f_s_size}, {62'd0, e.size});
      chk("busy_on", {63'd0, f_busy}, 64'd1);
    end
  endtask

  task automatic f_complete(input int ch, input logic [63:0] rd,
                            input logic [1:0] rsp);
    logic [3:0] er;
    logic [1:0] mr;
    er = '0;
    er[2*ch +: 2] = rsp;
    mr = '0;
    mr[ch] = 1'b1;
    f_s_ready = 1'b1;
    f_s_rdata = rd;
    f_s_resp  = rsp;
    #1;
    chk("m_ready", {62'd0, f_m_ready}, {62'd0, mr});
    chk("m_resp", {60'd0, f_m_resp}, {60'd0, er});
    chk("m_rdata0", f_m_rdata[63:0], (ch == 0) ? rd : 64'd0);
    chk("m_rdata1", f_m_rdata[127:64], (ch == 1) ? rd : 64'd0);
    step();
    f_s_ready = 1'b0;
    f_s_rdata = '0;
    f_s_resp  = '0;
    #1;
    chk("s_valid_fall", {63'd0, f_s_valid}, 64'd0);
    chk("busy_fall", {63'd0, f_busy}, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    f_m_valid = 2'b11; f_m_req = '0; f_m_addr = '0;
    f_m_wdata = '0; f_m_size = '0;
    f_s_ready = 1'b0; f_s_resp = '0; f_s_rdata = '0;
    r_m_valid = '0; r_m_req = '0; r_m_addr = '0;
    r_m_wdata = '0; r_m_size = '0;
    r_s_ready = 1'b0; r_s_resp = '0; r_s_rdata = '0;

    // reset with requests pending
    repeat (2) begin
      step();
      #1;
      chk("rst_s_valid", {63'd0, f_s_valid}, 64'd0);
      chk("rst_m_ready", {62'd0, f_m_ready}, 64'd0);
      chk("rst_busy", {63'd0, f_busy}, 64'd0);
    end

    // fixed priority: ch0 before ch1
    f_set(0, REQ_READ, 64'h8000_0000, 64'd0, SIZE_W);
    f_set(1, REQ_READ, 64'h8000_0100, 64'd0, SIZE_D);
    rst = 1'b0;
    f_wait_grant();
    f_m_valid = 2'b10;
    f_complete(0, 64'hDEAD, RESP_OKAY);
    f_wait_grant();
    f_m_valid = 2'b00;
    f_complete(1, 64'hBEEF, RESP_ERR);

    // write forwarding held stable across BUSY
    f_set(1, REQ_WRITE, 64'h8000_0200, 64'h1122_3344_5566_7788, SIZE_D);
    f_m_valid = 2'b10;
    f_wait_grant();
    f_m_valid = 2'b00;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("hold_valid", {63'd0, f_s_valid}, 64'd1);
      chk("hold_wdata", f_s_wdata, 64'h1122_3344_5566_7788);
      chk("hold_addr", f_s_addr, 64'h8000_0200);
      chk("hold_ready", {62'd0, f_m_ready}, 64'd0);
    end
    f_complete(1, 64'd0, RESP_OKAY);

    // reset collides with completion; s_ready in IDLE ignored
    f_set(0, REQ_READ, 64'h8000_0300, 64'd0, SIZE_B);
    f_m_valid = 2'b01;
    f_wait_grant();
    f_s_ready = 1'b1;
    f_s_rdata = 64'h55;
    rst = 1'b1;
    f_m_valid = 2'b00;
    #1;
    chk("rst_drop_ready", {62'd0, f_m_ready}, 64'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_idle_valid", {63'd0, f_s_valid}, 64'd0);
    chk("rst_idle_busy", {63'd0, f_busy}, 64'd0);
    chk("idle_sready", {62'd0, f_m_ready}, 64'd0);
    step();
    chk("idle_sready2", {62'd0, f_m_ready}, 64'd0);
    chk("idle_busy2", {63'd0, f_busy}, 64'd0);
    f_s_ready = 1'b0;
    f_s_rdata = '0;

`ifdef ARB_TIMEOUT_EN
    // timeout abort on BUSY cycle 16
    f_set(0, REQ_READ, 64'h8000_0400, 64'd0, SIZE_W);
    f_m_valid = 2'b01;
    f_wait_grant();
    f_s_rdata = 64'hFFFF;
    for (int k = 1; k < 16; k++) begin
      chk("tmo_early", {62'd0, f_m_ready}, 64'd0);
      step();
    end
    f_m_valid = 2'b00;
    #1;
    chk("tmo_ready", {62'd0, f_m_ready}, 64'd1);
    chk("tmo_resp", {60'd0, f_m_resp}, {62'd0, RESP_ERR});
    chk("tmo_rdata", f_m_rdata[63:0], 64'd0);
    step();
    chk("tmo_s_valid", {63'd0, f_s_valid}, 64'd0);
    f_s_rdata = '0;
`endif

    // round-robin order with all channels held valid
    for (int i = 0; i < 4; i++)
      r_m_addr[64*i +: 64] = 64'h1000 + 64'(i * 256);
    for (int i = 0; i < 8; i++) rq.push_back(i % 4);
    r_m_valid = 4'hF;
    for (int t = 0; t < 8; t++) begin
      int g;
      int n = 0;
      logic [3:0] mr;
      while (!r_s_valid && n < 20) begin
        step();
        n++;
      end
      chk("rr_valid", {63'd0, r_s_valid}, 64'd1);
      g = rq.pop_front();
      mr = '0;
      mr[g] = 1'b1;
      chk("rr_grant", {62'd0, r_grant_id}, 64'(g));
      chk("rr_addr", r_s_addr, 64'h1000 + 64'(g * 256));
      r_s_ready = 1'b1;
      #1;
      chk("rr_ready", {60'd0, r_m_ready}, {60'd0, mr});
      step();
      r_s_ready = 1'b0;
      #1;
    end
    r_m_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
